// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Streaming writer for the coprocessor weight memory. A start pulse (req)
// latches a base address and a word count. The loader then takes that many
// words from a valid/ready stream and writes them to consecutive memory
// addresses, wrapping modulo 2**WSIZE. busy stays high until the final write
// has committed, and done pulses for one cycle after that.
//
// Optional feature macro: WLOAD_CHECKSUM_EN
//   When it is defined, a running DWIDTH-bit wrapping sum of the accepted
//   words is kept and exposed on the checksum port.
//
// Parameters:
//   DWIDTH     weight word width (memory data width)
//   WSIZE      memory address width (depth 2**WSIZE)
//
// Ports:
//   clk        system clock, rising edge
//   xrst       asynchronous active-low reset
//   req        start pulse, honoured only in IDLE
//   base_addr  first write address, latched on an accepted req
//   count      number of words (0..2**WSIZE), latched on an accepted req
//   s_valid    stream word valid
//   s_data     stream word
//   s_ready    loader can take a word (state == LOAD)
//   mem_we     memory write enable (registered)
//   mem_addr   memory write address (registered)
//   write_data memory write data (registered)
//   busy       state is not IDLE
//   done       one-cycle completion pulse, the cycle after FLUSH
//   checksum   wrapping sum of the accepted words (WLOAD_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module weight_loader #(
  parameter int DWIDTH = 16,
  parameter int WSIZE  = 12
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     req,
  input  logic [WSIZE-1:0]         base_addr,
  input  logic [WSIZE:0]           count,
  input  logic                     s_valid,
  input  logic signed [DWIDTH-1:0] s_data,
  output logic                     s_ready,
  output logic                     mem_we,
  output logic [WSIZE-1:0]         mem_addr,
  output logic signed [DWIDTH-1:0] write_data,
  output logic                     busy,
  output logic                     done
`ifdef WLOAD_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0]        checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                     state_reg;
  state_t                     state_next;
  logic [WSIZE-1:0]           addr_reg;
  logic [WSIZE:0]             remaining_reg;
  logic                       mem_we_reg;
  logic [WSIZE-1:0]           mem_addr_reg;
  logic signed [DWIDTH-1:0]   write_data_reg;
  logic                       done_reg;
  logic                       start;
  logic                       beat;

  // A start is only honoured in IDLE; a beat is only taken in LOAD.
  assign start = req && (state_reg == IDLE);
  assign beat  = s_valid && (state_reg == LOAD);

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = (count == '0) ? FLUSH : LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && (remaining_reg == (WSIZE+1)'(1))) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address and remaining-word counters.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
    end else if (start) begin
      addr_reg      <= base_addr;
      remaining_reg <= count;
    end else if (beat) begin
      addr_reg      <= addr_reg + WSIZE'(1);  // wraps naturally at 2**WSIZE
      remaining_reg <= remaining_reg - (WSIZE+1)'(1);
    end
  end

  // Registered write port. Address and data hold between beats; only the
  // enable drops, so the memory sees a clean single-cycle strobe per word.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      write_data_reg <= '0;
    end else begin
      mem_we_reg <= beat;
      if (beat) begin
        mem_addr_reg   <= addr_reg;
        write_data_reg <= s_data;
      end
    end
  end

  // done follows FLUSH by one cycle, so it rises only after the last write
  // (issued during FLUSH) has been committed by the memory.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == FLUSH);
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign write_data = write_data_reg;
  assign done       = done_reg;

`ifdef WLOAD_CHECKSUM_EN
  logic [DWIDTH-1:0] checksum_reg;

  // Raw-bit wrapping sum. It holds after the run so that it is still valid
  // while done is high and until the next accepted req.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      checksum_reg <= '0;
    end else if (start) begin
      checksum_reg <= '0;
    end else if (beat) begin
      checksum_reg <= checksum_reg + $unsigned(s_data);
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//
// Directed bench for weight_loader. A table of load runs holds the base
// address, count, words, s_valid pattern, an optional stray req and the
// hand-computed last address and checksum. Each run is driven and checked
// cycle by cycle. Hand-written sequences cover reset, the full-depth run and
// the run started in the done cycle. A small memory model captures the write
// port so that the stored words can be read back.
// -----------------------------------------------------------------------------
module tb_weight_loader;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk;
  logic          xrst;
  logic          req;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic          busy;
  logic          done;
`ifdef WLOAD_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  weight_loader #(.DWIDTH(DW), .WSIZE(AW)) dut (
    .clk        (clk),
    .xrst       (xrst),
    .req        (req),
    .base_addr  (base_addr),
    .count      (count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .busy       (busy),
    .done       (done)
`ifdef WLOAD_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model driven by the write port, plus a done-pulse counter.
  logic [DW-1:0] mem_model [4096];
  int            done_pulses = 0;
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= write_data;
    if (done) done_pulses <= done_pulses + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [DW-1:0] w [4];
    logic [7:0]    vpat;   // s_valid for cycles 0..7 of the run, then held 1
    int            req_k;  // cycle of a stray req during LOAD, -1 for none
    logic [DW-1:0] sum;
    logic [AW-1:0] last;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] wbuf [4096];

  task automatic set_vec(input int idx, input logic [AW-1:0] base, input logic [AW:0] cnt,
                         input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                         input logic [7:0] vpat, input int req_k,
                         input logic [DW-1:0] sum, input logic [AW-1:0] last);
    vecs[idx].base  = base;
    vecs[idx].cnt   = cnt;
    vecs[idx].w[0]  = w0;
    vecs[idx].w[1]  = w1;
    vecs[idx].w[2]  = w2;
    vecs[idx].w[3]  = w3;
    vecs[idx].vpat  = vpat;
    vecs[idx].req_k = req_k;
    vecs[idx].sum   = sum;
    vecs[idx].last  = last;
  endtask

  // Starts at a negedge and ends at the negedge of the done cycle, so the
  // next call raises req inside the done cycle.
  task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] cnt,
                          input logic [7:0] vpat, input int req_k,
                          input logic [DW-1:0] exp_sum, input logic [AW-1:0] exp_last,
                          input string name);
    int            i;
    int            k;
    logic          acc;
    logic [AW-1:0] a_exp;
    i = 0;
    k = 0;
    req = 1'b1; base_addr = base; count = cnt;
    @(posedge clk); @(negedge clk);
    req = 1'b0; base_addr = 12'h555; count = 13'd1;
    check(busy, 1, {name, " busy_after_req"});
    if (cnt == 0) begin
      check(s_ready, 0, {name, " ready_in_flush"});
      check(mem_we, 0, {name, " we_in_flush"});
    end
    while (i < int'(cnt) && k < 20000) begin
      check(s_ready, 1, {name, " ready_in_load"});
      s_valid = (k < 8) ? vpat[k] : 1'b1;
      s_data  = wbuf[i];
      req     = (k == req_k);
      acc     = s_valid;
      @(posedge clk); @(negedge clk);
      req = 1'b0;
      s_valid = 1'b0;
      if (acc) begin
        a_exp = base + i[AW-1:0];
        check(mem_we, 1, {name, " we_on_beat"});
        check(mem_addr, a_exp, {name, " addr_on_beat"});
        check(write_data, wbuf[i], {name, " data_on_beat"});
        i++;
      end else begin
        check(mem_we, 0, {name, " we_in_gap"});
      end
      k++;
    end
    if (k >= 20000) check(i, cnt, {name, " beat_budget"});
    // FLUSH cycle: words offered now must be ignored.
    check(busy, 1, {name, " busy_in_flush"});
    check(done, 0, {name, " done_early"});
    check(s_ready, 0, {name, " ready_after_last"});
    s_valid = 1'b1; s_data = 16'h7777;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    check(done, 1, {name, " done_pulse"});
    check(busy, 0, {name, " busy_at_done"});
    check(mem_we, 0, {name, " no_write_at_done"});
    if (cnt != 0) check(mem_addr, exp_last, {name, " last_addr"});
`ifdef WLOAD_CHECKSUM_EN
    check(checksum, exp_sum, {name, " checksum"});
`endif
    for (int j = 0; j < int'(cnt); j++) begin
      a_exp = base + j[AW-1:0];
      if (mem_model[a_exp] !== wbuf[j]) check(mem_model[a_exp], wbuf[j], {name, " readback"});
    end
    checks++;  // the read-back sweep counts as one comparison when it is clean
  endtask

  task automatic idle_step(input string name);
    s_valid = 1'b1; s_data = 16'h7777;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    check(done, 0, {name, " done_one_cycle"});
    check(busy, 0, {name, " idle_busy"});
    check(mem_we, 0, {name, " idle_no_write"});
  endtask

  initial begin
    xrst = 1'b0; req = 1'b0; base_addr = '0; count = '0; s_valid = 1'b0; s_data = '0;

    set_vec(0, 12'h010, 13'd4, 16'd1, 16'd2, 16'd3, 16'hFFFC, 8'hFF, -1, 16'h0002, 12'h013);
    set_vec(1, 12'h100, 13'd3, 16'd5, 16'd6, 16'd7, 16'd0, 8'h29, -1, 16'h0012, 12'h102);
    set_vec(2, 12'hFFE, 13'd3, 16'd7, 16'd8, 16'd9, 16'd0, 8'hFF, -1, 16'h0018, 12'h000);
    set_vec(3, 12'h200, 13'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'hFF, -1, 16'h0000, 12'h000);
    set_vec(4, 12'h300, 13'd4, 16'd10, 16'd20, 16'd30, 16'd40, 8'hFF, 1, 16'h0064, 12'h303);
    set_vec(5, 12'hABC, 13'd3, 16'h7FFF, 16'h7FFF, 16'h0002, 16'd0, 8'hFF, -1, 16'h0000, 12'hABE);

    // Reset state.
    repeat (2) @(negedge clk);
    check(mem_we, 0, "rst mem_we");
    check(mem_addr, 0, "rst mem_addr");
    check(write_data, 0, "rst write_data");
    check(busy, 0, "rst busy");
    check(done, 0, "rst done");
    check(s_ready, 0, "rst s_ready");
`ifdef WLOAD_CHECKSUM_EN
    check(checksum, 0, "rst checksum");
`endif
    xrst = 1'b1;
    @(negedge clk);

    // Abort mid-LOAD after 2 of 5 words.
    req = 1'b1; base_addr = 12'h020; count = 13'd5;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    s_valid = 1'b1; s_data = 16'h1111;
    @(posedge clk); @(negedge clk);
    s_data = 16'h2222;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    check(mem_we, 1, "abort second write pending");
    #2 xrst = 1'b0;
    #1;
    check(mem_we, 0, "abort mem_we");
    check(mem_addr, 0, "abort mem_addr");
    check(write_data, 0, "abort write_data");
    check(busy, 0, "abort busy");
    check(s_ready, 0, "abort s_ready");
`ifdef WLOAD_CHECKSUM_EN
    check(checksum, 0, "abort checksum");
`endif
    repeat (3) begin
      @(negedge clk);
      check(done, 0, "abort no done");
    end
    check(mem_model[12'h020], 16'h1111, "abort committed word kept");
    xrst = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 5; j++) wbuf[j] = 16'h0A00 + 16'(j);
    run_load(12'h020, 13'd5, 8'hFF, -1, 16'h320A, 12'h024, "post_reset");
    idle_step("post_reset");

    // Table-driven runs.
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < 4; j++) wbuf[j] = vecs[v].w[j];
      run_load(vecs[v].base, vecs[v].cnt, vecs[v].vpat, vecs[v].req_k,
               vecs[v].sum, vecs[v].last, $sformatf("vec%0d", v));
      idle_step($sformatf("vec%0d", v));
    end

    // Full depth, then a second run requested in the done cycle.
    for (int j = 0; j < 4096; j++) wbuf[j] = 16'(j * 5 + 3);
    run_load(12'h000, 13'd4096, 8'hFF, -1, 16'h0800, 12'hFFF, "full_depth");
    wbuf[0] = 16'hBEEF; wbuf[1] = 16'h0001;
    run_load(12'h040, 13'd2, 8'hFF, -1, 16'hBEF0, 12'h041, "chained");
    idle_step("chained");

    check(done_pulses, 9, "total done pulses");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
